debug_core_agent: RTL and testbench
===================================

Name: debug_core_agent

Overview:
Core-side endpoint of the debug control link; consumes debug_hub's halt/run/step requests and breakpoint programming, and produces its trace stream.
Gates instruction issue at instruction boundaries through a RUN/HALT_PEND/HALTED/STEP state machine.
Holds a small exec-breakpoint table.
Emits 128-bit trace records through a 2-entry output buffer.

Parameters:
BP_COUNT, 4, number of breakpoint table entries (1..16)
TRACE_W, 128, trace record width (must be >=128; bits above 127 driven 0)

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
halt_req  in  1  level halt request from hub
run_req  in  1  level run request from hub
step_req  in  1  one-cycle step pulse from hub
halt_ack  out  1  high while state==HALTED
step_ack  out  1  one-cycle pulse on step completion
bp_valid  in  1  breakpoint programming request
bp_ready  out  1  programming accept
bp_write  in  1  1=write entry
bp_index  in  8  entry index
bp_addr  in  32  match address
bp_kind  in  4  kind; 4'h0=EXEC, others reserved
bp_enable  in  1  entry enable
core_pc_valid  in  1  core presents next-to-issue PC
core_pc  in  32  next-to-issue PC
core_issue_allow  out  1  core may issue this cycle
core_issue_fire  in  1  core issued an instruction this cycle
core_idle  in  1  no instruction in flight
core_retire_valid  in  1  instruction retired
core_retire_pc  in  32  retired PC
core_retire_insn  in  32  retired encoding
trace_valid  out  1  trace record valid
trace_ready  in  1  trace sink ready
trace_data  out  TRACE_W  trace record

Behaviour:
- Reset (async, all state): state=RUN, all bp entries disabled, skip=0, trace buffer empty, retire_count=0, drop flag=0.
- Outputs in reset: halt_ack=0, step_ack=0, bp_ready=0, trace_valid=0, trace_data=0. core_issue_allow follows the RUN equation.
- bp_ready: registered 1 from the first clock after reset release onward.
- bp write: commits on bp_valid && bp_ready && bp_write.
  - bp_index>=BP_COUNT: accepted, ignored.
  - Effect is visible to matching on the next cycle.
- bp_hit (combinational) requires all of:
  - state==RUN
  - core_pc_valid
  - !skip
  - some entry with enable && kind==EXEC && addr==core_pc
- core_issue_allow (combinational):
  - RUN: !halt_req && !bp_hit
  - STEP: !step_issued
  - HALT_PEND, HALTED: 0
- State transitions:
  - RUN -> HALT_PEND on halt_req or bp_hit; cause latched (HALT=1, BP=2).
  - HALT_PEND -> HALTED when core_idle. The cycle HALTED is entered, push halt-event record with pc=last retired PC.
  - HALTED + step_req -> STEP: clear step_issued, set skip.
  - HALTED + run_req && !halt_req -> RUN: set skip.
  - halt_req && run_req together: halt wins, stay HALTED.
  - step_req outside HALTED: ignored.
  - STEP: core_issue_fire sets step_issued. When step_issued && core_idle -> HALTED, step_ack pulses 1 cycle. No halt-event record for this re-entry.
  - skip clears on the first core_issue_fire after it is set.
- Trace record fields:
  - [31:0] pc
  - [63:32] insn (0 for events)
  - [95:64] retire_count: wrapping 32-bit, incremented per retire, value after increment
  - [99:96] type: 0=RETIRE, 1=HALT, 2=BP_HALT, 3=STEP_DONE
  - [100] drop flag
  - [127:101] 0
- Record sources:
  - Each core_retire_valid pushes a RETIRE record.
  - step completion pushes a STEP_DONE record with pc=last retired PC.
  - Same-cycle retire and event: retire record first, then event, order preserved. Needs 2 free slots; otherwise the event is dropped.
- Buffer: 2-entry FIFO. Pop on trace_valid && trace_ready; a pop and a push in the same cycle are both honoured.
- Full buffer: the record is dropped and the drop flag set; the next pushed record carries bit100=1, then the flag clears.
- retire_count increments regardless of drops.

Decomposition:
- carbon_arch_pkg additions: CARBON_DBG_BP_KIND_EXEC, trace event type codes (RETIRE/HALT/BP_HALT/STEP_DONE), trace record field offsets, agent state enum.
- Sub-module dbg_bp_match: breakpoint table storage plus parallel compare, outputs hit.

Test Plan:
- Reset, then run with core_pc_valid and no bps -> core_issue_allow=1, bp_ready=1 on the first cycle after reset, halt_ack=0.
- halt_req=1 with core_idle held 0 for 3 cycles -> allow=0, halt_ack rises 1 cycle after core_idle=1. Record type=1 emitted.
- Program idx0 addr=0x100 EXEC enable; core_pc=0x100 -> allow=0 that same cycle, HALTED, record type=2. Then run_req=1 -> 0x100 issues once, no re-hit.
- HALTED, step_req pulse -> exactly one issue allowed. After fire+idle: step_ack 1 cycle, record type=3, back to HALTED.
- trace_ready=0, 3 retires -> 2 records held, third dropped. With ready=1 and a new retire: records drain, next record has bit100=1 and retire_count=4.
- bp_index=9 (BP_COUNT=4) write accepted, no match effect. rst_n asserted in STEP -> RUN, buffer empty, trace_valid=0 immediately.

Source files
------------

// File: rtl/debug_core_agent_pkg.sv
// Shared definitions for the core-side debug agent: breakpoint kinds, trace
// record layout and type codes, and the agent state encoding.
package debug_core_agent_pkg;

  localparam logic [3:0] CARBON_DBG_BP_KIND_EXEC = 4'h0;

  localparam logic [3:0] TRC_TYPE_RETIRE    = 4'd0;
  localparam logic [3:0] TRC_TYPE_HALT      = 4'd1;
  localparam logic [3:0] TRC_TYPE_BP_HALT   = 4'd2;
  localparam logic [3:0] TRC_TYPE_STEP_DONE = 4'd3;

  localparam int unsigned TRC_REC_W    = 128;
  localparam int unsigned TRC_PC_LSB   = 0;
  localparam int unsigned TRC_INSN_LSB = 32;
  localparam int unsigned TRC_CNT_LSB  = 64;
  localparam int unsigned TRC_TYPE_LSB = 96;
  localparam int unsigned TRC_DROP_BIT = 100;

  typedef logic [TRC_REC_W-1:0] trace_rec_t;

  typedef enum logic [1:0] {
    AGENT_RUN,
    AGENT_HALT_PEND,
    AGENT_HALTED,
    AGENT_STEP
  } agent_state_e;

  function automatic trace_rec_t make_trace_rec(
    input logic [31:0] pc,
    input logic [31:0] insn,
    input logic [31:0] cnt,
    input logic [3:0]  typ,
    input logic        drop
  );
    trace_rec_t r;
    r = '0;
    r[TRC_PC_LSB   +: 32] = pc;
    r[TRC_INSN_LSB +: 32] = insn;
    r[TRC_CNT_LSB  +: 32] = cnt;
    r[TRC_TYPE_LSB +: 4]  = typ;
    r[TRC_DROP_BIT]       = drop;
    return r;
  endfunction

endpackage

// File: rtl/debug_core_agent_bp_match.sv
// Exec-breakpoint table: per-entry address/kind/enable storage and a parallel
// compare against the next-to-issue PC.
module dbg_bp_match
  import debug_core_agent_pkg::*;
#(
  parameter int unsigned BP_COUNT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic [7:0]  wr_index,
  input  logic [31:0] wr_addr,
  input  logic [3:0]  wr_kind,
  input  logic        wr_enable,
  input  logic [31:0] pc,
  output logic        hit
);

  logic [31:0] addr_q [BP_COUNT];
  logic [3:0]  kind_q [BP_COUNT];
  logic        en_q   [BP_COUNT];

  // Out-of-range indices match no entry and are silently absorbed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < BP_COUNT; i++) begin
        addr_q[i] <= '0;
        kind_q[i] <= '0;
        en_q[i]   <= 1'b0;
      end
    end else begin
      for (int unsigned i = 0; i < BP_COUNT; i++) begin
        if (wr_en && (wr_index == 8'(i))) begin
          addr_q[i] <= wr_addr;
          kind_q[i] <= wr_kind;
          en_q[i]   <= wr_enable;
        end
      end
    end
  end

  always_comb begin
    hit = 1'b0;
    for (int unsigned i = 0; i < BP_COUNT; i++) begin
      if (en_q[i] && (kind_q[i] == CARBON_DBG_BP_KIND_EXEC) && (addr_q[i] == pc))
        hit = 1'b1;
    end
  end

endmodule

// File: rtl/debug_core_agent.sv
// Core-side debug endpoint: gates instruction issue through a run/halt/step
// state machine, matches exec breakpoints and emits trace records via a 2-deep FIFO.
module debug_core_agent
  import debug_core_agent_pkg::*;
#(
  parameter int unsigned BP_COUNT = 4,
  parameter int unsigned TRACE_W  = 128
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               halt_req,
  input  logic               run_req,
  input  logic               step_req,
  output logic               halt_ack,
  output logic               step_ack,
  input  logic               bp_valid,
  output logic               bp_ready,
  input  logic               bp_write,
  input  logic [7:0]         bp_index,
  input  logic [31:0]        bp_addr,
  input  logic [3:0]         bp_kind,
  input  logic               bp_enable,
  input  logic               core_pc_valid,
  input  logic [31:0]        core_pc,
  output logic               core_issue_allow,
  input  logic               core_issue_fire,
  input  logic               core_idle,
  input  logic               core_retire_valid,
  input  logic [31:0]        core_retire_pc,
  input  logic [31:0]        core_retire_insn,
  output logic               trace_valid,
  input  logic               trace_ready,
  output logic [TRACE_W-1:0] trace_data
);

  agent_state_e state_q, state_d;
  logic         skip_q, skip_d;
  logic         step_issued_q, step_issued_d;
  logic [3:0]   cause_q, cause_d;
  logic         bp_ready_q;
  logic         step_ack_q;
  logic [31:0]  last_pc_q, last_pc_d;
  logic [31:0]  retire_count_q, retire_count_d;
  logic         drop_q, drop_d;
  trace_rec_t   fifo_q [2];
  trace_rec_t   fifo_d [2];
  logic [1:0]   level_q, level_d, free;

  logic match_hit, bp_hit, halt_evt, step_done, evt_valid, pop;
  logic [3:0] evt_type;

  dbg_bp_match #(.BP_COUNT(BP_COUNT)) u_bp_match (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (bp_valid && bp_ready_q && bp_write),
    .wr_index (bp_index),
    .wr_addr  (bp_addr),
    .wr_kind  (bp_kind),
    .wr_enable(bp_enable),
    .pc       (core_pc),
    .hit      (match_hit)
  );

  assign bp_hit   = (state_q == AGENT_RUN) && core_pc_valid && !skip_q && match_hit;
  assign halt_ack = (state_q == AGENT_HALTED);
  assign step_ack = step_ack_q;
  assign bp_ready = bp_ready_q;

  always_comb begin
    state_d          = state_q;
    skip_d           = skip_q;
    step_issued_d    = step_issued_q;
    cause_d          = cause_q;
    halt_evt         = 1'b0;
    step_done        = 1'b0;
    core_issue_allow = 1'b0;
    if (core_issue_fire) skip_d = 1'b0;
    unique case (state_q)
      AGENT_RUN: begin
        core_issue_allow = !halt_req && !bp_hit;
        if (halt_req || bp_hit) begin
          state_d = AGENT_HALT_PEND;
          cause_d = halt_req ? TRC_TYPE_HALT : TRC_TYPE_BP_HALT;
        end
      end
      AGENT_HALT_PEND: begin
        if (core_idle) begin
          state_d  = AGENT_HALTED;
          halt_evt = 1'b1;
        end
      end
      AGENT_HALTED: begin
        if (step_req) begin
          state_d       = AGENT_STEP;
          step_issued_d = 1'b0;
          skip_d        = 1'b1;
        end else if (run_req && !halt_req) begin
          state_d = AGENT_RUN;
          skip_d  = 1'b1;
        end
      end
      AGENT_STEP: begin
        core_issue_allow = !step_issued_q;
        if (core_issue_fire) step_issued_d = 1'b1;
        if (step_issued_q && core_idle) begin
          state_d   = AGENT_HALTED;
          step_done = 1'b1;
        end
      end
      default: state_d = AGENT_RUN;
    endcase
  end

  assign evt_valid   = halt_evt || step_done;
  assign evt_type    = halt_evt ? cause_q : TRC_TYPE_STEP_DONE;
  assign pop         = trace_valid && trace_ready;
  assign trace_valid = (level_q != 2'd0);

  // Pop is applied first so a full FIFO being drained still accepts a push;
  // a same-cycle retire+event pair is all-or-event-dropped, retire first.
  always_comb begin
    retire_count_d = retire_count_q + 32'(core_retire_valid);
    last_pc_d      = core_retire_valid ? core_retire_pc : last_pc_q;
    fifo_d         = fifo_q;
    level_d        = level_q;
    drop_d         = drop_q;
    if (pop) begin
      fifo_d[0] = fifo_q[1];
      level_d   = level_q - 2'd1;
    end
    free = 2'd2 - level_d;
    if (core_retire_valid && evt_valid) begin
      if (free == 2'd2) begin
        fifo_d[0] = make_trace_rec(core_retire_pc, core_retire_insn, retire_count_d,
                                   TRC_TYPE_RETIRE, drop_q);
        fifo_d[1] = make_trace_rec(last_pc_d, '0, retire_count_d, evt_type, 1'b0);
        level_d   = 2'd2;
        drop_d    = 1'b0;
      end else if (free == 2'd1) begin
        fifo_d[level_d[0]] = make_trace_rec(core_retire_pc, core_retire_insn,
                                            retire_count_d, TRC_TYPE_RETIRE, drop_q);
        level_d = 2'd2;
        drop_d  = 1'b1;
      end else begin
        drop_d = 1'b1;
      end
    end else if (core_retire_valid || evt_valid) begin
      if (free != 2'd0) begin
        fifo_d[level_d[0]] = core_retire_valid
          ? make_trace_rec(core_retire_pc, core_retire_insn, retire_count_d,
                           TRC_TYPE_RETIRE, drop_q)
          : make_trace_rec(last_pc_d, '0, retire_count_d, evt_type, drop_q);
        level_d = level_d + 2'd1;
        drop_d  = 1'b0;
      end else begin
        drop_d = 1'b1;
      end
    end
  end

  always_comb begin
    trace_data = '0;
    if (trace_valid) trace_data[TRC_REC_W-1:0] = fifo_q[0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= AGENT_RUN;
      skip_q         <= 1'b0;
      step_issued_q  <= 1'b0;
      cause_q        <= TRC_TYPE_HALT;
      bp_ready_q     <= 1'b0;
      step_ack_q     <= 1'b0;
      last_pc_q      <= '0;
      retire_count_q <= '0;
      drop_q         <= 1'b0;
      fifo_q[0]      <= '0;
      fifo_q[1]      <= '0;
      level_q        <= '0;
    end else begin
      state_q        <= state_d;
      skip_q         <= skip_d;
      step_issued_q  <= step_issued_d;
      cause_q        <= cause_d;
      bp_ready_q     <= 1'b1;
      step_ack_q     <= step_done;
      last_pc_q      <= last_pc_d;
      retire_count_q <= retire_count_d;
      drop_q         <= drop_d;
      fifo_q         <= fifo_d;
      level_q        <= level_d;
    end
  end

endmodule

// File: tb/tb_debug_core_agent.sv
// Self-checking bench for debug_core_agent: scenario tasks plus a trace
// scoreboard fed at stimulus time and drained by a record monitor.
module tb_debug_core_agent;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         halt_req, run_req, step_req;
  logic         halt_ack, step_ack;
  logic         bp_valid, bp_ready, bp_write, bp_enable;
  logic [7:0]   bp_index;
  logic [31:0]  bp_addr;
  logic [3:0]   bp_kind;
  logic         core_pc_valid, core_issue_allow, core_issue_fire, core_idle;
  logic [31:0]  core_pc;
  logic         core_retire_valid;
  logic [31:0]  core_retire_pc, core_retire_insn;
  logic         trace_valid, trace_ready;
  logic [127:0] trace_data;

  int unsigned  checks = 0;
  int unsigned  failures = 0;
  logic [127:0] exp_q[$];
  logic [31:0]  exp_cnt = 0;
  logic [31:0]  last_pc = 0;

  debug_core_agent #(.BP_COUNT(4), .TRACE_W(128)) dut (
    .clk(clk), .rst_n(rst_n),
    .halt_req(halt_req), .run_req(run_req), .step_req(step_req),
    .halt_ack(halt_ack), .step_ack(step_ack),
    .bp_valid(bp_valid), .bp_ready(bp_ready), .bp_write(bp_write),
    .bp_index(bp_index), .bp_addr(bp_addr), .bp_kind(bp_kind), .bp_enable(bp_enable),
    .core_pc_valid(core_pc_valid), .core_pc(core_pc),
    .core_issue_allow(core_issue_allow), .core_issue_fire(core_issue_fire),
    .core_idle(core_idle), .core_retire_valid(core_retire_valid),
    .core_retire_pc(core_retire_pc), .core_retire_insn(core_retire_insn),
    .trace_valid(trace_valid), .trace_ready(trace_ready), .trace_data(trace_data)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] rec(input logic [31:0] pc, input logic [31:0] insn,
                                       input logic [31:0] cnt, input logic [3:0] typ,
                                       input logic drop);
    return {27'b0, drop, typ, cnt, insn, pc};
  endfunction

  // Scoreboard side: every accepted record is compared with the oldest expected one.
  always @(negedge clk) begin
    if (rst_n && trace_valid && trace_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL trace_unexpected got=%h expected=none", trace_data);
      end else begin
        logic [127:0] e;
        e = exp_q.pop_front();
        if (trace_data !== e) begin
          failures++;
          $display("FAIL trace_record got=%h expected=%h", trace_data, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic retire(input logic [31:0] pc, input logic [31:0] insn,
                        input bit expect_rec, input logic drop);
    exp_cnt++;
    last_pc = pc;
    if (expect_rec) exp_q.push_back(rec(pc, insn, exp_cnt, 4'd0, drop));
    core_retire_valid = 1'b1;
    core_retire_pc    = pc;
    core_retire_insn  = insn;
    tick();
    core_retire_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && (exp_q.size() != 0 || trace_valid); i++) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; halt_req = 0; run_req = 0; step_req = 0;
    bp_valid = 0; bp_write = 0; bp_index = 0; bp_addr = 0; bp_kind = 0; bp_enable = 0;
    core_pc_valid = 1'b1; core_pc = 32'h100; core_issue_fire = 0; core_idle = 1'b1;
    core_retire_valid = 0; core_retire_pc = 0; core_retire_insn = 0; trace_ready = 1'b1;
    #2;
    checks += 4;
    if (halt_ack !== 1'b0) begin failures++; $display("FAIL rst_halt_ack got=%b exp=0", halt_ack); end
    if (bp_ready !== 1'b0) begin failures++; $display("FAIL rst_bp_ready got=%b exp=0", bp_ready); end
    if (trace_valid !== 1'b0 || trace_data !== '0) begin
      failures++; $display("FAIL rst_trace got=%b/%h exp=0/0", trace_valid, trace_data);
    end
    if (core_issue_allow !== 1'b1) begin failures++; $display("FAIL rst_allow got=%b exp=1", core_issue_allow); end
    tick(); tick();
    rst_n = 1'b1;
    tick();
    checks += 3;
    if (bp_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_first got=%b exp=1", bp_ready); end
    if (core_issue_allow !== 1'b1) begin failures++; $display("FAIL run_allow got=%b exp=1", core_issue_allow); end
    if (halt_ack !== 1'b0) begin failures++; $display("FAIL run_halt_ack got=%b exp=0", halt_ack); end
  endtask

  task automatic test_halt();
    retire(32'h40, 32'hdeadbeef, 1, 0);
    halt_req = 1'b1; core_idle = 1'b0;
    #1;
    checks++;
    if (core_issue_allow !== 1'b0) begin failures++; $display("FAIL halt_allow got=%b exp=0", core_issue_allow); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (halt_ack !== 1'b0) begin failures++; $display("FAIL halt_pend_ack cyc=%0d got=%b exp=0", i, halt_ack); end
    end
    exp_q.push_back(rec(last_pc, 32'h0, exp_cnt, 4'd1, 1'b0));
    core_idle = 1'b1;
    tick();
    checks += 2;
    if (halt_ack !== 1'b1) begin failures++; $display("FAIL halted_ack got=%b exp=1", halt_ack); end
    if (core_issue_allow !== 1'b0) begin failures++; $display("FAIL halted_allow got=%b exp=0", core_issue_allow); end
    halt_req = 1'b0; run_req = 1'b1;
    tick();
    run_req = 1'b0;
    core_issue_fire = 1'b1;
    tick();
    core_issue_fire = 1'b0;
    drain();
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL halt_records_left got=%0d exp=0", exp_q.size()); end
  endtask

  task automatic test_bp_halt();
    bp_valid = 1'b1; bp_write = 1'b1; bp_index = 8'd0; bp_addr = 32'h100;
    bp_kind = 4'h0; bp_enable = 1'b1;
    tick();
    bp_index = 8'd1; bp_addr = 32'h200; bp_kind = 4'h1;
    tick();
    bp_valid = 1'b0; bp_write = 1'b0;
    core_pc_valid = 1'b1; core_pc = 32'h100;
    #1;
    checks++;
    if (core_issue_allow !== 1'b0) begin failures++; $display("FAIL bp_allow got=%b exp=0", core_issue_allow); end
    exp_q.push_back(rec(last_pc, 32'h0, exp_cnt, 4'd2, 1'b0));
    tick(); tick();
    checks++;
    if (halt_ack !== 1'b1) begin failures++; $display("FAIL bp_halted got=%b exp=1", halt_ack); end
    run_req = 1'b1;
    tick();
    run_req = 1'b0;
    checks++;
    if (core_issue_allow !== 1'b1) begin failures++; $display("FAIL bp_skip_allow got=%b exp=1", core_issue_allow); end
    core_issue_fire = 1'b1;
    tick();
    core_issue_fire = 1'b0; core_pc = 32'h104;
    retire(32'h100, 32'h00000013, 1, 0);
    checks += 2;
    if (core_issue_allow !== 1'b1) begin failures++; $display("FAIL bp_after_allow got=%b exp=1", core_issue_allow); end
    if (halt_ack !== 1'b0) begin failures++; $display("FAIL bp_rehit got=%b exp=0", halt_ack); end
    core_pc_valid = 1'b0;
    drain();
  endtask

  task automatic test_step();
    halt_req = 1'b1;
    exp_q.push_back(rec(last_pc, 32'h0, exp_cnt, 4'd1, 1'b0));
    tick(); tick();
    halt_req = 1'b0;
    step_req = 1'b1;
    tick();
    step_req = 1'b0;
    checks += 2;
    if (core_issue_allow !== 1'b1) begin failures++; $display("FAIL step_allow got=%b exp=1", core_issue_allow); end
    if (halt_ack !== 1'b0) begin failures++; $display("FAIL step_halt_ack got=%b exp=0", halt_ack); end
    core_issue_fire = 1'b1; core_idle = 1'b0;
    tick();
    core_issue_fire = 1'b0;
    checks++;
    if (core_issue_allow !== 1'b0) begin failures++; $display("FAIL step_once got=%b exp=0", core_issue_allow); end
    retire(32'h104, 32'h00100093, 1, 0);
    exp_q.push_back(rec(last_pc, 32'h0, exp_cnt, 4'd3, 1'b0));
    core_idle = 1'b1;
    tick();
    checks += 2;
    if (step_ack !== 1'b1) begin failures++; $display("FAIL step_ack_hi got=%b exp=1", step_ack); end
    if (halt_ack !== 1'b1) begin failures++; $display("FAIL step_rehalt got=%b exp=1", halt_ack); end
    tick();
    checks++;
    if (step_ack !== 1'b0) begin failures++; $display("FAIL step_ack_pulse got=%b exp=0", step_ack); end
    drain();
  endtask

  task automatic test_drop();
    run_req = 1'b1;
    tick();
    run_req = 1'b0;
    trace_ready = 1'b0;
    retire(32'h200, 32'h11111111, 1, 0);
    retire(32'h204, 32'h22222222, 1, 0);
    retire(32'h208, 32'h33333333, 0, 0);
    checks++;
    if (trace_valid !== 1'b1) begin failures++; $display("FAIL drop_held got=%b exp=1", trace_valid); end
    trace_ready = 1'b1;
    retire(32'h20c, 32'h44444444, 1, 1);
    retire(32'h210, 32'h55555555, 1, 0);
    drain();
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL drop_records_left got=%0d exp=0", exp_q.size()); end
  endtask

  task automatic test_bp_oob();
    core_issue_fire = 1'b1;
    tick();
    core_issue_fire = 1'b0;
    bp_valid = 1'b1; bp_write = 1'b1; bp_index = 8'd9; bp_addr = 32'h300;
    bp_kind = 4'h0; bp_enable = 1'b1;
    tick();
    bp_valid = 1'b0; bp_write = 1'b0;
    core_pc_valid = 1'b1; core_pc = 32'h300;
    #1;
    checks++;
    if (core_issue_allow !== 1'b1) begin failures++; $display("FAIL oob_allow got=%b exp=1", core_issue_allow); end
    core_pc = 32'h200;
    #1;
    checks++;
    if (core_issue_allow !== 1'b1) begin failures++; $display("FAIL rsvd_kind_allow got=%b exp=1", core_issue_allow); end
    core_pc = 32'h100;
    #1;
    checks++;
    if (core_issue_allow !== 1'b0) begin failures++; $display("FAIL idx0_live got=%b exp=0", core_issue_allow); end
    core_pc_valid = 1'b0;
    tick();
    checks++;
    if (halt_ack !== 1'b0) begin failures++; $display("FAIL oob_halt got=%b exp=0", halt_ack); end
  endtask

  task automatic test_reset_in_step();
    halt_req = 1'b1;
    exp_q.push_back(rec(last_pc, 32'h0, exp_cnt, 4'd1, 1'b0));
    tick(); tick();
    halt_req = 1'b0;
    drain();
    step_req = 1'b1;
    tick();
    step_req = 1'b0;
    trace_ready = 1'b0;
    retire(32'h300, 32'h66666666, 0, 0);
    checks++;
    if (trace_valid !== 1'b1) begin failures++; $display("FAIL step_buf got=%b exp=1", trace_valid); end
    rst_n = 1'b0;
    #1;
    checks += 3;
    if (trace_valid !== 1'b0 || trace_data !== '0) begin
      failures++; $display("FAIL rst_step_trace got=%b/%h exp=0/0", trace_valid, trace_data);
    end
    if (core_issue_allow !== 1'b1) begin failures++; $display("FAIL rst_step_allow got=%b exp=1", core_issue_allow); end
    if (bp_ready !== 1'b0) begin failures++; $display("FAIL rst_step_bp_ready got=%b exp=0", bp_ready); end
    tick();
    rst_n = 1'b1;
    trace_ready = 1'b1;
    tick();
    core_pc_valid = 1'b1; core_pc = 32'h100;
    #1;
    checks++;
    if (core_issue_allow !== 1'b1) begin failures++; $display("FAIL rst_bp_cleared got=%b exp=1", core_issue_allow); end
    core_pc_valid = 1'b0;
    exp_cnt = 0;
    retire(32'h400, 32'h77777777, 1, 0);
    drain();
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL final_records_left got=%0d exp=0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_halt();
    test_bp_halt();
    test_step();
    test_drop();
    test_bp_oob();
    test_reset_in_step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
